// File: rtl/mop_sched_pkg.sv
// Shared types and width helpers for the multi-operand tree-sum scheduler.
package mop_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int calc_w(input int n, input int m);
    return m + $clog2(n);
  endfunction

  function automatic int calc_levels(input int n);
    return $clog2(n);
  endfunction

  // N=2 has a single pair, but the tag still needs one bit to exist.
  function automatic int calc_tag_w(input int n);
    return (n > 2) ? $clog2(n / 2) : 1;
  endfunction

endpackage

// File: rtl/mop_pair_add.sv
// Shared two-operand adder: alternating-polarity ripple carry, then ADD_LAT
// register stages carrying the issue valid and destination tag.
module mop_pair_add #(
  parameter int W       = 20,
  parameter int TW      = 3,
  parameter int ADD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [TW-1:0] issue_tag,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  output logic          res_valid,
  output logic [TW-1:0] res_tag,
  output logic [W-1:0]  res_sum
);

  logic [W-1:0]       sum_c;
  logic               cy;
  logic [W-1:0]       sum_q [ADD_LAT];
  logic [TW-1:0]      tag_q [ADD_LAT];
  logic [ADD_LAT-1:0] vld_q;

  // Even cells take a true carry and emit it inverted (OAI); odd cells take
  // the inverted carry and restore it (AOI on inverted inputs).
  always_comb begin
    sum_c = '0;
    cy    = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i % 2 == 0) begin
        sum_c[i] = op_a[i] ^ op_b[i] ^ cy;
        cy       = ~((op_a[i] | op_b[i]) & (cy | (op_a[i] & op_b[i])));
      end else begin
        sum_c[i] = op_a[i] ^ op_b[i] ^ ~cy;
        cy       = ~((~op_a[i] & ~op_b[i]) | (cy & (~op_a[i] | ~op_b[i])));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        sum_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      sum_q[0] <= sum_c;
      tag_q[0] <= issue_tag;
      vld_q[0] <= issue_valid;
      for (int i = 1; i < ADD_LAT; i++) begin
        sum_q[i] <= sum_q[i-1];
        tag_q[i] <= tag_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign res_valid = vld_q[ADD_LAT-1];
  assign res_tag   = tag_q[ADD_LAT-1];
  assign res_sum   = sum_q[ADD_LAT-1];

endmodule

// File: rtl/mop_tree_sched.sv
// Buffers N operands, reduces them pairwise level by level through one shared
// pipelined adder, and hands the sum out on a valid/ready port.
//   state  | meaning
//   IDLE   | waiting for the first operand of a job
//   LOAD   | collecting operands 1..N-1
//   REDUCE | issuing pairs per level; final cycle latches buf[0] to out_sum
//   DONE   | out_sum valid, held until out_ready
module mop_tree_sched
  import mop_sched_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int M       = 16,
  parameter  int ADD_LAT = 1,
  localparam int W       = calc_w(N, M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         busy
);

  localparam int LEVELS = calc_levels(N);
  localparam int TW     = calc_tag_w(N);
  localparam int LW     = $clog2(LEVELS + 1);
  localparam int CW     = $clog2(N / 2 + ADD_LAT) + 1;

  state_t              state_q, state_d;
  logic [W-1:0]        buf_q [N];
  logic [LEVELS-1:0]   cnt_q;
  logic [LW-1:0]       lvl_q;
  logic [CW-1:0]       cyc_q;
  logic [CW-1:0]       pairs, last_cyc;
  logic                lvl_live, in_fire, out_fire, last_load;
  logic [LEVELS-1:0]   idx_a, idx_b;
  logic                issue_valid, res_valid;
  logic [TW-1:0]       issue_tag, res_tag;
  logic [W-1:0]        op_a, op_b, res_sum;

  assign pairs     = CW'(N / 2) >> lvl_q;
  assign last_cyc  = pairs + CW'(ADD_LAT - 1);
  assign lvl_live  = (lvl_q != LW'(LEVELS));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_load = (cnt_q == LEVELS'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = LOAD;
      LOAD:    if (in_fire && last_load) state_d = REDUCE;
      REDUCE:  if (!lvl_live) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE) || (state_q == LOAD);
    busy        = (state_q != IDLE);
    out_valid   = (state_q == DONE);
    issue_valid = (state_q == REDUCE) && lvl_live && (cyc_q < pairs);
    issue_tag   = cyc_q[TW-1:0];
    idx_a       = LEVELS'({issue_tag, 1'b0});
    idx_b       = idx_a | LEVELS'(1);
    op_a        = buf_q[idx_a];
    op_b        = buf_q[idx_b];
  end

  // Writebacks land in buf[tag], always below the pair index still being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      cyc_q   <= '0;
      out_sum <= '0;
    end else begin
      if (res_valid) buf_q[LEVELS'(res_tag)] <= res_sum;
      case (state_q)
        IDLE: if (in_fire) begin
          buf_q[0] <= W'(in_data);
          cnt_q    <= LEVELS'(1);
        end
        LOAD: if (in_fire) begin
          buf_q[cnt_q] <= W'(in_data);
          cnt_q        <= cnt_q + 1'b1;
          lvl_q        <= '0;
          cyc_q        <= '0;
        end
        REDUCE: begin
          if (lvl_live) begin
            if (cyc_q == last_cyc) begin
              cyc_q <= '0;
              lvl_q <= lvl_q + 1'b1;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end else begin
            out_sum <= buf_q[0];
          end
        end
        DONE: if (out_fire) cnt_q <= '0;
        default: ;
      endcase
    end
  end

  mop_pair_add #(
    .W       (W),
    .TW      (TW),
    .ADD_LAT (ADD_LAT)
  ) u_add (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_tag     (res_tag),
    .res_sum     (res_sum)
  );

endmodule

// File: tb/tb_mop_tree_sched.sv
// Directed bench: three instances (N16/lat1, N16/lat3, N2/lat1) on one clock.
module tb_mop_tree_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data;
  logic [19:0] a_out_sum;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_data;
  logic [19:0] b_out_sum;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [15:0] c_in_data;
  logic [16:0] c_out_sum;

  mop_tree_sched #(.N(16), .M(16), .ADD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .busy(a_busy));

  mop_tree_sched #(.N(16), .M(16), .ADD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .busy(b_busy));

  mop_tree_sched #(.N(2), .M(16), .ADD_LAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .busy(c_busy));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_a(input logic [15:0] ops [16]);
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = ops[i];
      vec_cnt++;
      if (a_in_ready !== 1'b1) begin
        err_cnt++;
        $display("FAIL load_a_ready op%0d: got %b want 1", i, a_in_ready);
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    #22;
    vec_cnt++;
    if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    vec_cnt++;
    if (a_out_sum !== 20'h0) begin err_cnt++; $display("FAIL rst_out_sum: got %h want 00000", a_out_sum); end
    vec_cnt++;
    if (a_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    vec_cnt++;
    if (dut_a.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d want 0", dut_a.cnt_q); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_sum_seq();
    logic [15:0] ops [16];
    int lat;
    for (int i = 0; i < 16; i++) ops[i] = 16'(i + 1);
    a_out_ready = 1'b1;
    load_a(ops);
    vec_cnt++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL seq_reduce_flags: busy=%b in_ready=%b want 1/0", a_busy, a_in_ready);
    end
    wait_a(lat);
    vec_cnt++;
    if (lat != 20) begin err_cnt++; $display("FAIL seq_latency: got %0d want 20", lat); end
    vec_cnt++;
    if (a_out_sum !== 20'h00088) begin err_cnt++; $display("FAIL seq_sum: got %h want 00088", a_out_sum); end
    @(posedge clk); #1;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_done_1cyc: out_valid=%b in_ready=%b busy=%b want 0/1/0", a_out_valid, a_in_ready, a_busy);
    end
  endtask

  task automatic test_all_ones();
    logic [15:0] ops [16];
    int lat;
    for (int i = 0; i < 16; i++) ops[i] = 16'hFFFF;
    load_a(ops);
    wait_a(lat);
    vec_cnt++;
    if (lat != 20) begin err_cnt++; $display("FAIL ones_latency: got %0d want 20", lat); end
    vec_cnt++;
    if (a_out_sum !== 20'hFFFF0) begin err_cnt++; $display("FAIL ones_sum: got %h want ffff0", a_out_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_lat3();
    logic [31:0] mask;
    int lat;
    b_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i + 1);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    mask = '0;
    lat  = 0;
    while (b_out_valid !== 1'b1 && lat < 200) begin
      if (lat < 32) mask[lat] = dut_b.issue_valid;
      @(posedge clk); #1;
      lat++;
    end
    vec_cnt++;
    if (lat != 28) begin err_cnt++; $display("FAIL lat3_latency: got %0d want 28", lat); end
    vec_cnt++;
    if (b_out_sum !== 20'h00088) begin err_cnt++; $display("FAIL lat3_sum: got %h want 00088", b_out_sum); end
    // levels issue at cycles 0-7, 11-14, 18-19, 23
    vec_cnt++;
    if (mask !== 32'h008C78FF) begin err_cnt++; $display("FAIL lat3_issue_sched: got %h want 008c78ff", mask); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] ops [16];
    int lat;
    int bad;
    for (int i = 0; i < 16; i++) ops[i] = 16'(i + 1);
    a_out_ready = 1'b0;
    load_a(ops);
    wait_a(lat);
    vec_cnt++;
    if (lat != 20) begin err_cnt++; $display("FAIL bp_latency: got %0d want 20", lat); end
    for (int k = 0; k < 10; k++) begin
      vec_cnt++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 20'h00088 || a_in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold cyc%0d: valid=%b sum=%h in_ready=%b want 1/00088/0", k, a_out_valid, a_out_sum, a_in_ready);
      end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL bp_release: valid=%b in_ready=%b want 0/1", a_out_valid, a_in_ready);
    end
    for (int i = 0; i < 16; i++) ops[i] = 16'h0002;
    load_a(ops);
    wait_a(lat);
    bad = (a_out_sum !== 20'h00020) ? 1 : 0;
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL bp_second_job: got %h want 00020", a_out_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_reduce();
    logic [15:0] ops [16];
    int lat;
    for (int i = 0; i < 16; i++) ops[i] = 16'(i + 1);
    load_a(ops);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_out_sum !== 20'h0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_outputs: valid=%b sum=%h busy=%b in_ready=%b want 0/00000/0/1",
               a_out_valid, a_out_sum, a_busy, a_in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_a(ops);
    wait_a(lat);
    vec_cnt++;
    if (lat != 20 || a_out_sum !== 20'h00088) begin
      err_cnt++; $display("FAIL midrst_next_job: lat=%0d sum=%h want 20/00088", lat, a_out_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n2_bubbles();
    logic        vseq [5];
    logic [15:0] dseq [5];
    int lat;
    vseq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dseq = '{16'h5555, 16'hFFFF, 16'hAAAA, 16'h7777, 16'h0001};
    c_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_in_valid = vseq[i];
      c_in_data  = dseq[i];
      @(posedge clk); #1;
    end
    c_in_valid = 1'b1;
    c_in_data  = 16'h1234;
    lat = 0;
    while (c_out_valid !== 1'b1 && lat < 50) begin
      vec_cnt++;
      if (c_in_ready !== 1'b0) begin err_cnt++; $display("FAIL n2_reduce_ready cyc%0d: got %b want 0", lat, c_in_ready); end
      @(posedge clk); #1;
      lat++;
    end
    c_in_valid = 1'b0;
    vec_cnt++;
    if (lat != 3) begin err_cnt++; $display("FAIL n2_latency: got %0d want 3", lat); end
    vec_cnt++;
    if (c_out_sum !== 17'h10000) begin err_cnt++; $display("FAIL n2_sum: got %h want 10000", c_out_sum); end
    @(posedge clk); #1;
    vec_cnt++;
    if (c_busy !== 1'b0 || c_out_valid !== 1'b0) begin
      err_cnt++; $display("FAIL n2_after: busy=%b valid=%b want 0/0", c_busy, c_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sum_seq();
    test_all_ones();
    test_add_lat3();
    test_backpressure();
    test_reset_mid_reduce();
    test_n2_bubbles();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
